// File: rtl/bus_port_fifo.sv
// Device-side bus port: a TX FIFO toward the bus and a destination-filtered
// RX FIFO toward the device, both first-word fall-through.
module bus_port_fifo_q #(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr,
  input  logic [width-1:0]             wr_data,
  input  logic                         rd,
  output logic [width-1:0]             head,
  output logic [$clog2(depth+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int ptr_w = $clog2(depth);
  localparam int cnt_w = $clog2(depth+1);

  logic [width-1:0] mem [depth];
  logic [ptr_w-1:0] wr_ptr;
  logic [ptr_w-1:0] rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + ptr_w'(1);
      if (rd) rd_ptr <= rd_ptr + ptr_w'(1);
      case ({wr, rd})
        2'b10:   count <= count + cnt_w'(1);
        2'b01:   count <= count - cnt_w'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is gated to zero while empty.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wr_data;
  end

  assign empty = (count == '0);
  assign full  = (count == cnt_w'(depth));
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

module bus_port_fifo #(
  parameter int         pckg_sz = 16,
  parameter int         depth   = 8,
  parameter logic [7:0] id      = 8'h00,
  parameter logic [7:0] bcast   = 8'hFF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         dev_wr_en,
  input  logic [pckg_sz-1:0]           dev_wr_data,
  output logic                         tx_full,
  output logic [$clog2(depth+1)-1:0]   tx_count,
  output logic                         pndng,
  output logic [pckg_sz-1:0]           D_pop,
  input  logic                         pop,
  input  logic                         push,
  input  logic [pckg_sz-1:0]           D_push,
  input  logic                         dev_rd_en,
  output logic [pckg_sz-1:0]           dev_rd_data,
  output logic                         rx_empty,
  output logic [$clog2(depth+1)-1:0]   rx_count,
  output logic [7:0]                   ovf_cnt,
  output logic [7:0]                   misroute_cnt,
  output logic                         pop_err
);

  logic       tx_empty;
  logic       tx_pop;
  logic       tx_wr;
  logic       tx_ovf;
  logic       rx_full;
  logic       rx_rd;
  logic       rx_wr;
  logic       rx_ovf;
  logic [7:0] dest;
  logic       dest_ok;
  logic       misroute;
  logic [8:0] ovf_sum;
  logic [7:0] ovf_next;

  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign tx_pop = pop & ~tx_empty;
  assign tx_wr  = dev_wr_en & (~tx_full | tx_pop);
  assign tx_ovf = dev_wr_en & ~tx_wr;

  assign dest     = D_push[pckg_sz-1 -: 8];
  assign dest_ok  = (dest == id) || (dest == bcast);
  assign misroute = push & ~dest_ok;
  assign rx_rd    = dev_rd_en & ~rx_empty;
  assign rx_wr    = push & dest_ok & (~rx_full | rx_rd);
  assign rx_ovf   = push & dest_ok & ~rx_wr;

  assign ovf_sum  = {1'b0, ovf_cnt} + 9'(tx_ovf) + 9'(rx_ovf);
  assign ovf_next = ovf_sum[8] ? 8'hFF : ovf_sum[7:0];

  bus_port_fifo_q #(
    .width (pckg_sz),
    .depth (depth)
  ) u_tx (
    .clk     (clk),
    .reset   (reset),
    .wr      (tx_wr),
    .wr_data (dev_wr_data),
    .rd      (tx_pop),
    .head    (D_pop),
    .count   (tx_count),
    .empty   (tx_empty),
    .full    (tx_full)
  );

  bus_port_fifo_q #(
    .width (pckg_sz),
    .depth (depth)
  ) u_rx (
    .clk     (clk),
    .reset   (reset),
    .wr      (rx_wr),
    .wr_data (D_push),
    .rd      (rx_rd),
    .head    (dev_rd_data),
    .count   (rx_count),
    .empty   (rx_empty),
    .full    (rx_full)
  );

  assign pndng = ~tx_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_cnt      <= '0;
      misroute_cnt <= '0;
      pop_err      <= 1'b0;
    end else begin
      ovf_cnt <= ovf_next;
      if (misroute && misroute_cnt != 8'hFF)
        misroute_cnt <= misroute_cnt + 8'd1;
      if (pop && tx_empty)
        pop_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_port_fifo.sv
// Randomized and directed bench for bus_port_fifo against a queue-based
// model of the port's TX/RX buffering and error counters.
module tb_bus_port_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        dev_wr_en;
  logic [15:0] dev_wr_data;
  logic        tx_full;
  logic [3:0]  tx_count;
  logic        pndng;
  logic [15:0] D_pop;
  logic        pop;
  logic        push;
  logic [15:0] D_push;
  logic        dev_rd_en;
  logic [15:0] dev_rd_data;
  logic        rx_empty;
  logic [3:0]  rx_count;
  logic [7:0]  ovf_cnt;
  logic [7:0]  misroute_cnt;
  logic        pop_err;

  bus_port_fifo #(
    .pckg_sz (16),
    .depth   (8),
    .id      (8'h03),
    .bcast   (8'hFF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .dev_wr_en    (dev_wr_en),
    .dev_wr_data  (dev_wr_data),
    .tx_full      (tx_full),
    .tx_count     (tx_count),
    .pndng        (pndng),
    .D_pop        (D_pop),
    .pop          (pop),
    .push         (push),
    .D_push       (D_push),
    .dev_rd_en    (dev_rd_en),
    .dev_rd_data  (dev_rd_data),
    .rx_empty     (rx_empty),
    .rx_count     (rx_count),
    .ovf_cnt      (ovf_cnt),
    .misroute_cnt (misroute_cnt),
    .pop_err      (pop_err)
  );

  always #5 clk = ~clk;

  logic [15:0] txq[$];
  logic [15:0] rxq[$];
  int          ovf_m;
  int          mis_m;
  bit          perr_m;
  int          n_cmp;
  int          n_bad;
  bit          run_chk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    txq.delete();
    rxq.delete();
    ovf_m  = 0;
    mis_m  = 0;
    perr_m = 0;
  endtask

  task automatic model_step(input logic w, input logic [15:0] wd,
                            input logic p, input logic ps,
                            input logic [15:0] pd, input logic r);
    bit pop_ok, wr_ok, rd_ok;
    int inc;
    inc    = 0;
    pop_ok = p && txq.size() > 0;
    wr_ok  = w && (txq.size() < 8 || pop_ok);
    if (p && txq.size() == 0) perr_m = 1;
    if (w && !wr_ok) inc++;
    rd_ok = r && rxq.size() > 0;
    if (pop_ok) void'(txq.pop_front());
    if (wr_ok) txq.push_back(wd);
    if (ps) begin
      if (pd[15:8] != 8'h03 && pd[15:8] != 8'hFF) begin
        if (mis_m < 255) mis_m++;
      end else if (!(rxq.size() < 8 || rd_ok)) begin
        inc++;
      end
    end
    if (rd_ok) void'(rxq.pop_front());
    if (ps && (pd[15:8] == 8'h03 || pd[15:8] == 8'hFF) &&
        (rxq.size() < 8))
      rxq.push_back(pd);
    ovf_m = (ovf_m + inc > 255) ? 255 : ovf_m + inc;
  endtask

  task automatic compare_all();
    check("pndng", 32'(pndng), 32'(txq.size() > 0));
    check("D_pop", 32'(D_pop), txq.size() > 0 ? 32'(txq[0]) : 32'd0);
    check("tx_count", 32'(tx_count), 32'(txq.size()));
    check("tx_full", 32'(tx_full), 32'(txq.size() == 8));
    check("rx_empty", 32'(rx_empty), 32'(rxq.size() == 0));
    check("dev_rd_data", 32'(dev_rd_data),
          rxq.size() > 0 ? 32'(rxq[0]) : 32'd0);
    check("rx_count", 32'(rx_count), 32'(rxq.size()));
    check("ovf_cnt", 32'(ovf_cnt), 32'(ovf_m));
    check("misroute_cnt", 32'(misroute_cnt), 32'(mis_m));
    check("pop_err", 32'(pop_err), 32'(perr_m));
  endtask

  always @(posedge clk) begin
    #1;
    if (run_chk && !reset) compare_all();
  end

  task automatic idle();
    dev_wr_en   = 0;
    dev_wr_data = '0;
    pop         = 0;
    push        = 0;
    D_push      = '0;
    dev_rd_en   = 0;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cyc(input logic w, input logic [15:0] wd, input logic p,
                     input logic ps, input logic [15:0] pd, input logic r);
    dev_wr_en   = w;
    dev_wr_data = wd;
    pop         = p;
    push        = ps;
    D_push      = pd;
    dev_rd_en   = r;
    @(posedge clk);
    model_step(w, wd, p, ps, pd, r);
    @(negedge clk);
    idle();
  endtask

  logic [15:0] exp_d;
  logic [7:0]  dst;
  int          wp, pp, sp, rp;

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    run_chk = 0;
    idle();
    model_clear();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_chk = 1;

    check("rst_pndng", 32'(pndng), 32'd0);
    check("rst_rx_empty", 32'(rx_empty), 32'd1);
    check("rst_D_pop", 32'(D_pop), 32'd0);
    check("rst_tx_full", 32'(tx_full), 32'd0);

    cyc(1, 16'h0AB1, 0, 0, 0, 0);
    check("first_pndng", 32'(pndng), 32'd1);
    check("first_D_pop", 32'(D_pop), 32'h0AB1);
    cyc(1, 16'h0AB2, 0, 0, 0, 0);
    cyc(1, 16'h0AB3, 0, 0, 0, 0);
    check("tx_count3", 32'(tx_count), 32'd3);
    for (int i = 1; i <= 3; i++) begin
      exp_d = 16'h0AB0 + 16'(i);
      check("pop_order", 32'(D_pop), 32'(exp_d));
      cyc(0, 0, 1, 0, 0, 0);
    end
    check("drained_pndng", 32'(pndng), 32'd0);
    check("drained_D_pop", 32'(D_pop), 32'd0);

    for (int i = 0; i < 8; i++) cyc(1, 16'h1100 + 16'(i), 0, 0, 0, 0);
    check("tx_full8", 32'(tx_full), 32'd1);
    cyc(1, 16'h11AA, 0, 0, 0, 0);
    check("ovf_after_drop", 32'(ovf_cnt), 32'd1);
    check("drop_count", 32'(tx_count), 32'd8);
    cyc(1, 16'h11BB, 1, 0, 0, 0);
    check("full_wr_pop_cnt", 32'(tx_count), 32'd8);
    check("full_wr_pop_head", 32'(D_pop), 32'h1101);
    repeat (8) cyc(0, 0, 1, 0, 0, 0);

    cyc(0, 0, 0, 1, 16'h0311, 0);
    cyc(0, 0, 0, 1, 16'hFF22, 0);
    cyc(0, 0, 0, 1, 16'h0533, 0);
    check("rx_count2", 32'(rx_count), 32'd2);
    check("misroute1", 32'(misroute_cnt), 32'd1);
    check("rx_head", 32'(dev_rd_data), 32'h0311);
    cyc(0, 0, 0, 0, 0, 1);
    check("rx_head2", 32'(dev_rd_data), 32'hFF22);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    check("rx_rd_empty_noflag", 32'(pop_err), 32'd0);

    cyc(0, 0, 1, 0, 0, 0);
    check("pop_err_set", 32'(pop_err), 32'd1);
    cyc(1, 16'h2222, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    check("pop_err_sticky", 32'(pop_err), 32'd1);
    for (int i = 0; i < 300; i++) cyc(0, 0, 0, 1, 16'h0500 + 16'(i % 256), 0);
    check("misroute_sat", 32'(misroute_cnt), 32'd255);

    for (int i = 0; i < 8; i++)
      cyc(1, 16'h3300 + 16'(i), 0, 1, 16'h0340 + 16'(i), 0);
    cyc(1, 16'h33FF, 0, 1, 16'hFF99, 0);
    check("dual_ovf", 32'(ovf_cnt), 32'd3);
    repeat (3) cyc(0, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    check("pre_rst_tx5", 32'(tx_count), 32'd5);
    check("pre_rst_rx4", 32'(rx_count), 32'd4);

    #2;
    reset = 1'b1;
    #1;
    check("arst_pndng", 32'(pndng), 32'd0);
    check("arst_rx_empty", 32'(rx_empty), 32'd1);
    check("arst_tx_count", 32'(tx_count), 32'd0);
    check("arst_rx_count", 32'(rx_count), 32'd0);
    check("arst_ovf", 32'(ovf_cnt), 32'd0);
    check("arst_mis", 32'(misroute_cnt), 32'd0);
    check("arst_pop_err", 32'(pop_err), 32'd0);
    check("arst_D_pop", 32'(D_pop), 32'd0);
    check("arst_rd_data", 32'(dev_rd_data), 32'd0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      cyc(1, 16'h4000 + 16'(i), 0, 1, 16'h0300 + 16'(i), 0);
      check("wrap_tx", 32'(D_pop), 32'h4000 + 32'(i));
      check("wrap_rx", 32'(dev_rd_data), 32'h0300 + 32'(i));
      cyc(0, 0, 1, 0, 0, 1);
    end
    check("wrap_tx0", 32'(tx_count), 32'd0);
    check("wrap_rx0", 32'(rx_count), 32'd0);
    check("wrap_ovf", 32'(ovf_cnt), 32'd0);
    check("wrap_mis", 32'(misroute_cnt), 32'd0);
    check("wrap_perr", 32'(pop_err), 32'd0);

    for (int ph = 0; ph < 4; ph++) begin
      wp = (ph == 1) ? 80 : (ph == 2) ? 20 : 50;
      pp = (ph == 1) ? 20 : (ph == 2) ? 80 : 45;
      sp = (ph == 1) ? 85 : 50;
      rp = (ph == 1) ? 15 : (ph == 2) ? 85 : 45;
      for (int n = 0; n < 700; n++) begin
        case ($urandom_range(0, 3))
          0, 1:    dst = 8'h03;
          2:       dst = 8'hFF;
          default: dst = 8'($urandom);
        endcase
        cyc($urandom_range(0, 99) < wp, 16'($urandom),
            $urandom_range(0, 99) < pp,
            $urandom_range(0, 99) < sp, {dst, 8'($urandom)},
            $urandom_range(0, 99) < rp);
      end
    end

    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
